requant_sequencer: RTL and testbench
====================================

REQUANT_SEQUENCER -- requirements
Module: requant_sequencer

Interface
REQ-001 SHALL have port clk, input, 1: sole clock; all state changes on rising edge.
REQ-002 SHALL have port rst, input, 1: synchronous, active-high reset.
REQ-003 SHALL have port start, input, 1: one-cycle pulse; side info valid for a new granule/channel.
REQ-004 SHALL have ports window_switching_flag (1), block_type (2), mixed_block_flag (1), big_values (9), all inputs, sampled only on the cycle start is accepted.
REQ-005 SHALL have ports x_valid (input, 1) and x_in (input, 16): sample from the Huffman stage, two's complement.
REQ-006 SHALL have port x_ready, output, 1: sample accepted when x_valid && x_ready.
REQ-007 SHALL have ports x_out (16), is_pos (10), sfb (4), win (2), band_type (2), dout_v (1), all outputs: registered tagged sample. band_type encoding: 0 long, 1 short, 2 count1/zero region.
REQ-008 SHALL have ports busy (output, 1) and gr_done (output, 1): gr_done is a one-cycle pulse.

Function
REQ-009 SHALL implement FSM IDLE -> LOAD -> RUN -> DONE -> IDLE.
REQ-010 IDLE: start=1 SHALL latch side info and move to LOAD. start is ignored in every other state.
REQ-011 LOAD: SHALL clear the position, band, window and sfb counters and compute count1_lim = 2*big_values (10 bit); next state RUN.
REQ-012 x_ready SHALL be 1 only in RUN; busy SHALL be 1 in LOAD, RUN and DONE.
REQ-013 RUN: each accepted sample SHALL be registered with its tags; dout_v=1 exactly one cycle later (latency 1). No accept means dout_v=0 and all counters hold.
REQ-014 Tagging SHALL use the position value before increment; is_pos runs 0..575 with no gaps.
REQ-015 Block class: short if window_switching_flag && block_type==2; mixed if short && mixed_block_flag; otherwise long.
REQ-016 Long band starts SHALL be 0,4,8,12,16,20,24,30,36,44,52,62,74,90,110,134,162,196,238,288,342,418; sfb 21 runs to 575; win=0.
REQ-017 Short band widths for sfb 0..12 SHALL be 4,4,4,4,6,8,10,12,14,18,22,30,56.
  - Each band is traversed as win 0, then 1, then 2, width samples each.
  - win wraps 2 -> 0 and sfb increments at the band end.
REQ-018 Mixed blocks: pos 0..35 SHALL be long (sfb 0..7, win 0); pos 36 SHALL start short sfb 3, win 0, continuing per REQ-017.
REQ-019 pos >= count1_lim SHALL give band_type=2, win=0, and sfb held at its last value; x_out SHALL still pass x_in unchanged in all regions.
REQ-020 Band and window tracking SHALL be counter-based (band_cnt, win, sfb); no per-sample table search over pos.
REQ-021 Acceptance of pos 575 SHALL move the FSM to DONE; DONE SHALL assert gr_done for one cycle, then return to IDLE.
REQ-022 big_values >= 288 SHALL mean no count1 region (count1_lim >= 576).
REQ-023 big_values=0 SHALL give band_type=2 for all 576 samples.

Reset
REQ-024 rst SHALL force, on the next edge:
  - state = IDLE;
  - all counters = 0;
  - x_ready, dout_v, busy, gr_done = 0;
  - x_out, is_pos, sfb, win, band_type = 0.
REQ-025 rst during RUN SHALL abandon the granule; no gr_done is produced. Reset has priority over start and x_valid in the same cycle.

Verification
REQ-026 Long block, big_values=100, x_valid held high. Required:
  - dout_v on 576 consecutive cycles;
  - pos 3: sfb 0; pos 4: sfb 1; pos 199: band_type 0, sfb 15;
  - pos 200: band_type 2;
  - gr_done exactly once.
REQ-027 Short non-mixed block, big_values=288. Required:
  - pos 0..3: sfb 0, win 0; pos 4..7: win 1; pos 8..11: win 2; pos 12: sfb 1, win 0;
  - pos 48..53: sfb 4, win 0; pos 408: sfb 12, win 0; pos 520: sfb 12, win 2.
REQ-028 Mixed block, big_values=288. Required:
  - pos 30..35: band_type 0, sfb 7, win 0;
  - pos 36: band_type 1, sfb 3, win 0; pos 40: win 1.
REQ-029 Backpressure: x_valid toggled randomly. Required:
  - is_pos strictly sequential, tags identical to the REQ-026 run;
  - dout_v count = 576.
REQ-030 start pulsed mid-RUN -> ignored. rst at pos 100 -> outputs 0 next cycle, no gr_done. New start after rst -> begins at pos 0, sfb 0.

Source files
------------

// File: rtl/requant_sequencer.sv
// Requantizer side-info sequencer: walks the 576 samples of one granule/channel and
// tags each accepted sample with its position, scalefactor band, window and region class.
module requant_sequencer (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic        window_switching_flag,
    input  logic [1:0]  block_type,
    input  logic        mixed_block_flag,
    input  logic [8:0]  big_values,
    input  logic        x_valid,
    input  logic [15:0] x_in,
    output logic        x_ready,
    output logic [15:0] x_out,
    output logic [9:0]  is_pos,
    output logic [3:0]  sfb,
    output logic [1:0]  win,
    output logic [1:0]  band_type,
    output logic        dout_v,
    output logic        busy,
    output logic        gr_done,
    output logic [1:0]  state_dbg
);

    // Handshake: a sample moves when x_valid && x_ready on a rising edge; x_ready is high only in RUN.
    typedef enum logic [1:0] {S_IDLE, S_LOAD, S_RUN, S_DONE} state_t;

    state_t      state_q, state_d;
    logic        wsf_q, wsf_d, mbf_q, mbf_d;
    logic [1:0]  bt_q, bt_d;
    logic [8:0]  bv_q, bv_d;
    logic [9:0]  lim_q, lim_d;
    logic [9:0]  pos_q, pos_d;
    logic [7:0]  band_cnt_q, band_cnt_d;
    logic [1:0]  win_q, win_d;
    logic [4:0]  sfb_cnt_q, sfb_cnt_d;
    logic [15:0] x_out_q, x_out_d;
    logic [9:0]  is_pos_q, is_pos_d;
    logic [3:0]  sfb_out_q, sfb_out_d;
    logic [1:0]  win_out_q, win_out_d;
    logic [1:0]  band_type_q, band_type_d;
    logic        dout_v_q, dout_v_d;

    logic        is_short, is_mixed, short_mode, in_count1, band_end;
    logic [7:0]  width;

    function automatic logic [7:0] long_width(input logic [4:0] s);
        case (s)
            5'd0, 5'd1, 5'd2, 5'd3, 5'd4, 5'd5: long_width = 8'd4;
            5'd6, 5'd7:   long_width = 8'd6;
            5'd8, 5'd9:   long_width = 8'd8;
            5'd10:        long_width = 8'd10;
            5'd11:        long_width = 8'd12;
            5'd12:        long_width = 8'd16;
            5'd13:        long_width = 8'd20;
            5'd14:        long_width = 8'd24;
            5'd15:        long_width = 8'd28;
            5'd16:        long_width = 8'd34;
            5'd17:        long_width = 8'd42;
            5'd18:        long_width = 8'd50;
            5'd19:        long_width = 8'd54;
            5'd20:        long_width = 8'd76;
            default:      long_width = 8'd158;
        endcase
    endfunction

    function automatic logic [7:0] short_width(input logic [4:0] s);
        case (s)
            5'd0, 5'd1, 5'd2, 5'd3: short_width = 8'd4;
            5'd4:         short_width = 8'd6;
            5'd5:         short_width = 8'd8;
            5'd6:         short_width = 8'd10;
            5'd7:         short_width = 8'd12;
            5'd8:         short_width = 8'd14;
            5'd9:         short_width = 8'd18;
            5'd10:        short_width = 8'd22;
            5'd11:        short_width = 8'd30;
            default:      short_width = 8'd56;
        endcase
    endfunction

    always_comb begin
        state_d     = state_q;
        wsf_d       = wsf_q;
        bt_d        = bt_q;
        mbf_d       = mbf_q;
        bv_d        = bv_q;
        lim_d       = lim_q;
        pos_d       = pos_q;
        band_cnt_d  = band_cnt_q;
        win_d       = win_q;
        sfb_cnt_d   = sfb_cnt_q;
        x_out_d     = x_out_q;
        is_pos_d    = is_pos_q;
        sfb_out_d   = sfb_out_q;
        win_out_d   = win_out_q;
        band_type_d = band_type_q;
        dout_v_d    = 1'b0;

        is_short   = wsf_q && (bt_q == 2'd2);
        is_mixed   = is_short && mbf_q;
        short_mode = is_short && !(is_mixed && (pos_q < 10'd36));
        in_count1  = (pos_q >= lim_q);
        width      = short_mode ? short_width(sfb_cnt_q) : long_width(sfb_cnt_q);
        band_end   = (band_cnt_q == width - 8'd1);

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    wsf_d   = window_switching_flag;
                    bt_d    = block_type;
                    mbf_d   = mixed_block_flag;
                    bv_d    = big_values;
                    state_d = S_LOAD;
                end
            end
            S_LOAD: begin
                pos_d      = 10'd0;
                band_cnt_d = 8'd0;
                win_d      = 2'd0;
                sfb_cnt_d  = 5'd0;
                lim_d      = {bv_q, 1'b0};
                state_d    = S_RUN;
            end
            S_RUN: begin
                if (x_valid) begin
                    x_out_d     = x_in;
                    is_pos_d    = pos_q;
                    // The 4-bit sfb port saturates for long bands 16..21.
                    sfb_out_d   = (sfb_cnt_q > 5'd15) ? 4'd15 : sfb_cnt_q[3:0];
                    win_out_d   = in_count1 ? 2'd0 : win_q;
                    band_type_d = in_count1 ? 2'd2 : (short_mode ? 2'd1 : 2'd0);
                    dout_v_d    = 1'b1;
                    pos_d       = pos_q + 10'd1;
                    // Band counters freeze once the next sample falls in the count1 region,
                    // so that region reports the sfb of the last big-values sample.
                    if (pos_q + 10'd1 < lim_q) begin
                        if (is_mixed && (pos_q == 10'd35)) begin
                            band_cnt_d = 8'd0;
                            win_d      = 2'd0;
                            sfb_cnt_d  = 5'd3;
                        end else if (!band_end) begin
                            band_cnt_d = band_cnt_q + 8'd1;
                        end else begin
                            band_cnt_d = 8'd0;
                            if (short_mode && (win_q != 2'd2)) begin
                                win_d = win_q + 2'd1;
                            end else begin
                                win_d     = 2'd0;
                                sfb_cnt_d = sfb_cnt_q + 5'd1;
                            end
                        end
                    end
                    if (pos_q == 10'd575) state_d = S_DONE;
                end
            end
            S_DONE: state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            wsf_q       <= 1'b0;
            bt_q        <= 2'd0;
            mbf_q       <= 1'b0;
            bv_q        <= 9'd0;
            lim_q       <= 10'd0;
            pos_q       <= 10'd0;
            band_cnt_q  <= 8'd0;
            win_q       <= 2'd0;
            sfb_cnt_q   <= 5'd0;
            x_out_q     <= 16'd0;
            is_pos_q    <= 10'd0;
            sfb_out_q   <= 4'd0;
            win_out_q   <= 2'd0;
            band_type_q <= 2'd0;
            dout_v_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            wsf_q       <= wsf_d;
            bt_q        <= bt_d;
            mbf_q       <= mbf_d;
            bv_q        <= bv_d;
            lim_q       <= lim_d;
            pos_q       <= pos_d;
            band_cnt_q  <= band_cnt_d;
            win_q       <= win_d;
            sfb_cnt_q   <= sfb_cnt_d;
            x_out_q     <= x_out_d;
            is_pos_q    <= is_pos_d;
            sfb_out_q   <= sfb_out_d;
            win_out_q   <= win_out_d;
            band_type_q <= band_type_d;
            dout_v_q    <= dout_v_d;
        end
    end

    assign x_ready   = (state_q == S_RUN);
    assign busy      = (state_q != S_IDLE);
    assign gr_done   = (state_q == S_DONE);
    assign state_dbg = state_q;
    assign x_out     = x_out_q;
    assign is_pos    = is_pos_q;
    assign sfb       = sfb_out_q;
    assign win       = win_out_q;
    assign band_type = band_type_q;
    assign dout_v    = dout_v_q;

endmodule

// File: tb/tb_requant_sequencer.sv
// Bench for requant_sequencer: random samples against a band-table reference model,
// hand-derived spot-check table, and reset / start-ignore sequences.
module tb_requant_sequencer;

    logic        clk = 1'b0;
    logic        rst, start, wsf, mbf, x_valid;
    logic [1:0]  bt;
    logic [8:0]  bv;
    logic [15:0] x_in;
    logic        x_ready, dout_v, busy, gr_done;
    logic [15:0] x_out;
    logic [9:0]  is_pos;
    logic [3:0]  sfb;
    logic [1:0]  win, band_type, state_dbg;

    requant_sequencer dut (
        .clk(clk), .rst(rst), .start(start),
        .window_switching_flag(wsf), .block_type(bt), .mixed_block_flag(mbf),
        .big_values(bv), .x_valid(x_valid), .x_in(x_in), .x_ready(x_ready),
        .x_out(x_out), .is_pos(is_pos), .sfb(sfb), .win(win), .band_type(band_type),
        .dout_v(dout_v), .busy(busy), .gr_done(gr_done), .state_dbg(state_dbg)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad = 0;

    function automatic void check(string name, int act, int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s actual=%0d required=%0d", name, act, exp);
        end
    endfunction

    // Reference model: per-position tags expanded from the band tables
    int m_sfb[576];
    int m_win[576];
    int m_bt[576];

    function automatic void build_model(input bit w, input int b, input bit m, input int bvv);
        int ls[23];
        int sw[13];
        bit shrt;
        int p;
        int s0;
        int lim;
        int hold;
        ls = '{0, 4, 8, 12, 16, 20, 24, 30, 36, 44, 52, 62, 74, 90, 110, 134, 162, 196,
               238, 288, 342, 418, 576};
        sw = '{4, 4, 4, 4, 6, 8, 10, 12, 14, 18, 22, 30, 56};
        shrt = w && (b == 2);
        s0 = 0;
        if (!shrt) begin
            for (int s = 0; s < 22; s++)
                for (int k = ls[s]; k < ls[s+1]; k++) begin
                    m_sfb[k] = s; m_win[k] = 0; m_bt[k] = 0;
                end
        end else begin
            p = 0;
            if (m) begin
                for (int s = 0; s < 8; s++)
                    for (int k = ls[s]; k < ls[s+1]; k++) begin
                        m_sfb[k] = s; m_win[k] = 0; m_bt[k] = 0;
                    end
                p = 36;
                s0 = 3;
            end
            for (int s = s0; s < 13; s++)
                for (int w2 = 0; w2 < 3; w2++)
                    for (int k = 0; k < sw[s]; k++) begin
                        m_sfb[p] = s; m_win[p] = w2; m_bt[p] = 1; p++;
                    end
        end
        lim = 2 * bvv;
        if (lim < 576) begin
            hold = (lim == 0) ? 0 : m_sfb[lim-1];
            for (int k = lim; k < 576; k++) begin
                m_sfb[k] = hold; m_win[k] = 0; m_bt[k] = 2;
            end
        end
    endfunction

    // Scoreboard / monitor state
    logic [15:0] exp_q[$];
    int mon_pos, dout_cnt, gr_cnt, run_len, max_run;
    int cap_sfb[576];
    int cap_win[576];
    int cap_bt[576];

    always @(negedge clk) begin
        if (gr_done) gr_cnt++;
        if (dout_v) begin
            logic [15:0] xe;
            int es;
            dout_cnt++;
            run_len++;
            if (run_len > max_run) max_run = run_len;
            if (exp_q.size() == 0) check("unexpected_dout", 1, 0);
            else begin
                xe = exp_q.pop_front();
                check("x_out", int'(x_out), int'(xe));
            end
            check("is_pos_seq", int'(is_pos), mon_pos);
            if (mon_pos < 576) begin
                es = (m_sfb[mon_pos] > 15) ? 15 : m_sfb[mon_pos];
                check("sfb", int'(sfb), es);
                check("win", int'(win), m_win[mon_pos]);
                check("band_type", int'(band_type), m_bt[mon_pos]);
            end
            if (is_pos < 576) begin
                cap_sfb[is_pos] = sfb; cap_win[is_pos] = win; cap_bt[is_pos] = band_type;
            end
            mon_pos++;
        end else begin
            run_len = 0;
        end
    end

    // Spot-check table: hand-derived tags for the three directed configurations
    typedef struct { int cfg; int pos; int sfb; int win; int bt; } spot_t;
    spot_t spots[$];

    task automatic start_granule(input bit w, input int b, input bit m, input int bvv);
        build_model(w, b, m, bvv);
        mon_pos = 0; dout_cnt = 0; gr_cnt = 0; max_run = 0; run_len = 0;
        for (int i = 0; i < 576; i++) begin
            cap_sfb[i] = -1; cap_win[i] = -1; cap_bt[i] = -1;
        end
        @(negedge clk);
        wsf = w; bt = b[1:0]; mbf = m; bv = bvv[8:0]; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic feed(input int n, input int pct);
        int sent = 0;
        int cyc = 0;
        while (sent < n && cyc < 5000) begin
            @(negedge clk);
            cyc++;
            x_valid = ($urandom_range(1, 100) <= pct);
            x_in = 16'($urandom);
            if (x_valid && x_ready) begin
                exp_q.push_back(x_in);
                sent++;
            end
        end
        if (sent < n) check("feed_timeout", sent, n);
    endtask

    task automatic finish_granule(input bit all_valid);
        int cyc = 0;
        @(negedge clk);
        x_valid = 1'b0;
        while (gr_cnt == 0 && cyc < 50) begin
            @(negedge clk);
            cyc++;
        end
        repeat (4) @(negedge clk);
        check("gr_done_count", gr_cnt, 1);
        check("dout_count", dout_cnt, 576);
        check("queue_empty", exp_q.size(), 0);
        check("idle_after_done", int'(busy), 0);
        if (all_valid) check("dout_consecutive", max_run, 576);
    endtask

    task automatic apply_spots(input int c);
        foreach (spots[i]) begin
            if (spots[i].cfg == c) begin
                check($sformatf("spot%0d_sfb@%0d", c, spots[i].pos), cap_sfb[spots[i].pos], spots[i].sfb);
                check($sformatf("spot%0d_win@%0d", c, spots[i].pos), cap_win[spots[i].pos], spots[i].win);
                check($sformatf("spot%0d_bt@%0d", c, spots[i].pos), cap_bt[spots[i].pos], spots[i].bt);
            end
        end
    endtask

    task automatic check_zero(input string tag);
        check({tag, "_dout_v"}, int'(dout_v), 0);
        check({tag, "_x_out"}, int'(x_out), 0);
        check({tag, "_is_pos"}, int'(is_pos), 0);
        check({tag, "_sfb"}, int'(sfb), 0);
        check({tag, "_win"}, int'(win), 0);
        check({tag, "_band_type"}, int'(band_type), 0);
        check({tag, "_busy"}, int'(busy), 0);
        check({tag, "_x_ready"}, int'(x_ready), 0);
        check({tag, "_gr_done"}, int'(gr_done), 0);
        check({tag, "_state"}, int'(state_dbg), 0);
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; wsf = 1'b0; bt = 2'd0; mbf = 1'b0; bv = 9'd0;
        x_valid = 1'b0; x_in = 16'd0;
        mon_pos = 0; dout_cnt = 0; gr_cnt = 0; run_len = 0; max_run = 0;

        spots.push_back('{0, 3, 0, 0, 0});    spots.push_back('{0, 4, 1, 0, 0});
        spots.push_back('{0, 35, 7, 0, 0});   spots.push_back('{0, 199, 15, 0, 0});
        spots.push_back('{0, 200, 15, 0, 2}); spots.push_back('{0, 575, 15, 0, 2});
        spots.push_back('{1, 0, 0, 0, 1});    spots.push_back('{1, 3, 0, 0, 1});
        spots.push_back('{1, 4, 0, 1, 1});    spots.push_back('{1, 7, 0, 1, 1});
        spots.push_back('{1, 8, 0, 2, 1});    spots.push_back('{1, 11, 0, 2, 1});
        spots.push_back('{1, 12, 1, 0, 1});   spots.push_back('{1, 48, 4, 0, 1});
        spots.push_back('{1, 53, 4, 0, 1});   spots.push_back('{1, 408, 12, 0, 1});
        spots.push_back('{1, 520, 12, 2, 1}); spots.push_back('{1, 575, 12, 2, 1});
        spots.push_back('{2, 30, 7, 0, 0});   spots.push_back('{2, 35, 7, 0, 0});
        spots.push_back('{2, 36, 3, 0, 1});   spots.push_back('{2, 40, 3, 1, 1});
        spots.push_back('{2, 44, 3, 2, 1});   spots.push_back('{2, 48, 4, 0, 1});

        repeat (3) @(negedge clk);
        check_zero("reset");
        @(negedge clk);
        rst = 1'b0;

        // Directed configurations with x_valid held high
        start_granule(1'b0, 0, 1'b0, 100); feed(576, 100); finish_granule(1'b1); apply_spots(0);
        start_granule(1'b1, 2, 1'b0, 288); feed(576, 100); finish_granule(1'b1); apply_spots(1);
        start_granule(1'b1, 2, 1'b1, 288); feed(576, 100); finish_granule(1'b1); apply_spots(2);

        // Backpressure: same tags as the held-valid long run
        start_granule(1'b0, 0, 1'b0, 100); feed(576, 50); finish_granule(1'b0); apply_spots(0);

        // Boundary side info, then random configurations
        start_granule(1'b0, 0, 1'b0, 0);   feed(576, 80); finish_granule(1'b0);
        start_granule(1'b1, 2, 1'b0, 511); feed(576, 70); finish_granule(1'b0);
        start_granule(1'b1, 2, 1'b1, 20);  feed(576, 90); finish_granule(1'b0);
        for (int r = 0; r < 4; r++) begin
            start_granule(1'($urandom_range(0, 1)), $urandom_range(0, 3),
                          1'($urandom_range(0, 1)), $urandom_range(0, 511));
            feed(576, $urandom_range(30, 100));
            finish_granule(1'b0);
        end

        // start pulsed mid-run with different side info is ignored
        start_granule(1'b1, 2, 1'b0, 288);
        feed(50, 100);
        @(negedge clk);
        x_valid = 1'b0; start = 1'b1; wsf = 1'b0; bt = 2'd0; bv = 9'd0;
        @(negedge clk);
        start = 1'b0;
        feed(526, 100);
        finish_granule(1'b0);
        apply_spots(1);

        // Reset at pos 100 abandons the granule; reset wins over start and x_valid
        start_granule(1'b0, 0, 1'b0, 100);
        feed(100, 100);
        @(negedge clk);
        rst = 1'b1; start = 1'b1; x_valid = 1'b1;
        @(negedge clk);
        rst = 1'b0; start = 1'b0; x_valid = 1'b0;
        check_zero("midrun_reset");
        check("abort_queue_empty", exp_q.size(), 0);
        repeat (10) @(negedge clk);
        check("abort_no_gr_done", gr_cnt, 0);
        check("abort_dout_count", dout_cnt, 100);
        check("abort_idle", int'(busy), 0);

        // Fresh granule after reset starts at pos 0, sfb 0
        start_granule(1'b0, 0, 1'b0, 100); feed(576, 100); finish_granule(1'b1); apply_spots(0);
        check("restart_pos0_sfb", cap_sfb[0], 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
